// File: rtl/vedic_mul_seq8.sv
// vedic_mul_seq8 -- sequential 8x8 unsigned multiplier built from a single
// 4x4 Vedic (Urdhva-Tiryagbhyam) multiplier reused over four cycles.
//
// Ports:
//   clk        single clock, rising-edge
//   rst        synchronous, active-high reset
//   in_valid   A/B presented for multiplication
//   in_ready   block can accept operands this cycle (IDLE only)
//   A, B       8-bit unsigned operands
//   out_valid  P holds a completed product (DONE only)
//   out_ready  consumer accepts P this cycle
//   P          16-bit unsigned product (tracks the accumulator in all states)
//   busy       high while partial products are being accumulated
//
// Also contains the leaf multipliers vedic_mul_bit2 (2x2) and vedic_mul_bit4 (4x4).

// 2x2 -> 4-bit Vedic multiplier: vertical and crosswise bit products.
module vedic_mul_bit2 (
    input  logic [1:0] a,
    input  logic [1:0] b,
    output logic [3:0] p
);
    logic cross_a1b0;
    logic cross_a0b1;
    logic c1;

    assign cross_a1b0 = a[1] & b[0];
    assign cross_a0b1 = a[0] & b[1];
    assign c1         = cross_a1b0 & cross_a0b1;

    assign p[0] = a[0] & b[0];
    assign p[1] = cross_a1b0 ^ cross_a0b1;
    assign p[2] = (a[1] & b[1]) ^ c1;
    assign p[3] = (a[1] & b[1]) & c1;
endmodule

// 4x4 -> 8-bit Vedic multiplier composed of four 2x2 blocks.
module vedic_mul_bit4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [7:0] p
);
    logic [3:0] q_ll;
    logic [3:0] q_hl;
    logic [3:0] q_lh;
    logic [3:0] q_hh;

    vedic_mul_bit2 u_ll (.a(a[1:0]), .b(b[1:0]), .p(q_ll));
    vedic_mul_bit2 u_hl (.a(a[3:2]), .b(b[1:0]), .p(q_hl));
    vedic_mul_bit2 u_lh (.a(a[1:0]), .b(b[3:2]), .p(q_lh));
    vedic_mul_bit2 u_hh (.a(a[3:2]), .b(b[3:2]), .p(q_hh));

    // Max 15*15 = 225, so the 8-bit sum never overflows.
    assign p = {4'b0000, q_ll}
             + {2'b00, q_hl, 2'b00}
             + {2'b00, q_lh, 2'b00}
             + {q_hh, 4'b0000};
endmodule

module vedic_mul_seq8 (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  A,
    input  logic [7:0]  B,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] P,
    output logic        busy
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [7:0]  a_q;
    logic [7:0]  b_q;
    logic [15:0] acc_q;
    logic [1:0]  step_q;

    logic [3:0]  pa;
    logic [3:0]  pb;
    logic [7:0]  pp;
    logic [15:0] pp_shifted;

    // step[1] selects the A nibble, step[0] the B nibble:
    // 0: Alo*Blo, 1: Alo*Bhi, 2: Ahi*Blo, 3: Ahi*Bhi.
    assign pa = step_q[1] ? a_q[7:4] : a_q[3:0];
    assign pb = step_q[0] ? b_q[7:4] : b_q[3:0];

    vedic_mul_bit4 u_mul4 (.a(pa), .b(pb), .p(pp));

    always_comb begin
        pp_shifted = '0;
        case (step_q)
            2'd0:    pp_shifted = {8'h00, pp};
            2'd3:    pp_shifted = {pp, 8'h00};
            default: pp_shifted = {4'h0, pp, 4'h0};
        endcase
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_d = MUL;
            end
            MUL: begin
                busy = 1'b1;
                if (step_q == 2'd3) state_d = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            step_q  <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q    <= A;
                        b_q    <= B;
                        acc_q  <= '0;
                        step_q <= '0;
                    end
                end
                MUL: begin
                    acc_q  <= acc_q + pp_shifted;
                    step_q <= step_q + 2'd1;
                end
                default: ;
            endcase
        end
    end

    assign P = acc_q;
endmodule

// File: tb/tb_vedic_mul_seq8.sv
// Testbench for vedic_mul_seq8: directed handshake/latency/reset checks plus a
// randomized run against a plain A*B reference queue.
module tb_vedic_mul_seq8;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  A;
    logic [7:0]  B;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] P;
    logic        busy;

    int checks = 0;
    int errors = 0;

    vedic_mul_seq8 dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .P         (P),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One transaction: accept, measure latency/busy length, optional stall, handshake.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input int stall, input string tag);
        int unsigned e;
        int lat;
        int busy_cnt;
        e = int'(a) * int'(b);
        chk({tag, ".in_ready_before"}, in_ready, 1);
        A = a;
        B = b;
        in_valid = 1'b1;
        out_ready = (stall == 0);
        tick();
        in_valid = 1'b0;
        A = 8'($urandom);
        B = 8'($urandom);
        lat = 0;
        busy_cnt = 0;
        while (!out_valid && lat < 20) begin
            if (busy) busy_cnt++;
            tick();
            lat++;
        end
        chk({tag, ".latency"}, lat, 4);
        chk({tag, ".busy_cycles"}, busy_cnt, 4);
        chk({tag, ".P"}, P, e);
        for (int i = 0; i < stall; i++) begin
            tick();
            chk({tag, ".stall_valid"}, out_valid, 1);
            chk({tag, ".stall_P"}, P, e);
            chk({tag, ".stall_in_ready"}, in_ready, 0);
        end
        out_ready = 1'b1;
        tick();
        chk({tag, ".post_out_valid"}, out_valid, 0);
        chk({tag, ".post_in_ready"}, in_ready, 1);
        chk({tag, ".post_busy"}, busy, 0);
    endtask

    initial begin : main
        int unsigned exp_q[$];
        int unsigned e;
        int issued;
        int got;
        int cyc;
        int lat;
        int spurious;

        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        A = '0;
        B = '0;
        tick();
        tick();
        rst = 1'b0;
        chk("reset.in_ready", in_ready, 1);
        chk("reset.out_valid", out_valid, 0);
        chk("reset.busy", busy, 0);
        chk("reset.P", P, 0);

        // Idle with in_valid low and out_ready high does nothing.
        out_ready = 1'b1;
        tick();
        tick();
        chk("idle.in_ready", in_ready, 1);
        chk("idle.out_valid", out_valid, 0);

        run_op(8'h12, 8'h34, 0, "basic");
        chk("basic.P_value", P, 16'h03A8);
        run_op(8'hFF, 8'hFF, 0, "maxmax");
        run_op(8'h00, 8'h5A, 0, "zero");
        run_op(8'h0F, 8'hF0, 0, "nibbles");
        run_op(8'h80, 8'h02, 5, "backpressure");

        // Operands offered during MUL must be ignored.
        A = 8'h03;
        B = 8'h05;
        in_valid = 1'b1;
        out_ready = 1'b1;
        tick();
        A = 8'hAA;
        B = 8'hBB;
        lat = 0;
        while (!out_valid && lat < 20) begin
            chk("ignore.in_ready_low", in_ready, 0);
            tick();
            lat++;
        end
        chk("ignore.latency", lat, 4);
        chk("ignore.P", P, 16'h000F);
        tick();
        chk("ignore.idle_in_ready", in_ready, 1);
        chk("ignore.idle_out_valid", out_valid, 0);
        tick();
        in_valid = 1'b0;
        chk("ignore.second_accepted", busy, 1);
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        e = 32'hAA * 32'hBB;
        chk("ignore.second_P", P, e);
        tick();

        // Reset mid-operation (during step 2).
        A = 8'h55;
        B = 8'h66;
        in_valid = 1'b1;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        chk("midrst.busy_before", busy, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst.in_ready", in_ready, 1);
        chk("midrst.busy", busy, 0);
        chk("midrst.out_valid", out_valid, 0);
        chk("midrst.P", P, 0);
        spurious = 0;
        for (int i = 0; i < 8; i++) begin
            if (out_valid) spurious++;
            tick();
        end
        chk("midrst.no_out_valid", spurious, 0);
        run_op(8'h07, 8'h09, 0, "after_rst");

        // Reset has priority over in_valid.
        rst = 1'b1;
        in_valid = 1'b1;
        A = 8'h11;
        B = 8'h22;
        tick();
        rst = 1'b0;
        in_valid = 1'b0;
        chk("rstprio.busy", busy, 0);
        chk("rstprio.in_ready", in_ready, 1);
        chk("rstprio.P", P, 0);

        // Randomized traffic against a queue of A*B.
        issued = 0;
        got = 0;
        cyc = 0;
        while ((issued < 1000 || exp_q.size() > 0) && cyc < 40000) begin
            in_valid = (issued < 1000) && ($urandom_range(0, 3) != 0);
            A = 8'($urandom);
            B = 8'($urandom);
            out_ready = ($urandom_range(0, 2) != 0);
            if (in_valid && in_ready) begin
                exp_q.push_back(int'(A) * int'(B));
                issued++;
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("rand.P", P, e);
                    got++;
                end else begin
                    chk("rand.unexpected_output", out_valid, 0);
                end
            end
            tick();
            cyc++;
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        chk("rand.outputs_received", got, 1000);
        chk("rand.queue_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/vedic_mul_seq8.md
VEDIC_MUL_SEQ8 -- requirements
Module: vedic_mul_seq8

Interface
REQ-001: Parameters: none; operand width fixed at 8 bits, product width at 16 bits.
REQ-002: clk  input  1  single clock; all state updates on rising edge.
REQ-003: rst  input  1  reset, synchronous, active-high.
REQ-004: in_valid  input  1  operands A, B presented for multiplication.
REQ-005: in_ready  output  1  block can accept operands this cycle.
REQ-006: A  input  8  multiplicand, unsigned.
REQ-007: B  input  8  multiplier, unsigned.
REQ-008: out_valid  output  1  P holds a completed product.
REQ-009: out_ready  input  1  consumer accepts P this cycle.
REQ-010: P  output  16  unsigned product A*B.
REQ-011: busy  output  1  high while state is MUL.

Function
REQ-012: The block SHALL instantiate exactly one vedic_mul_bit4 (4x4 -> 8-bit unsigned) and time-multiplex it to form one 8x8 product.
REQ-013: FSM states SHALL be IDLE, MUL, DONE.
REQ-014: IDLE: in_ready=1, out_valid=0, busy=0.
REQ-015: Acceptance SHALL occur on a rising edge where in_valid=1 and in_ready=1: A, B registered into operand registers, 16-bit accumulator cleared to 0, 2-bit step counter set to 0, state -> MUL.
REQ-016: In IDLE with in_valid=0, the state SHALL remain IDLE and registers SHALL hold.
REQ-017: MUL: in_ready=0, busy=1, out_valid=0; A, B, in_valid SHALL be ignored.
REQ-018: Step order, one per cycle: step 0 = A[3:0]*B[3:0] added at shift 0; step 1 = A[3:0]*B[7:4] at shift 4; step 2 = A[7:4]*B[3:0] at shift 4; step 3 = A[7:4]*B[7:4] at shift 8.
REQ-019: Each MUL edge SHALL add the selected 8-bit partial product, zero-extended and shifted, into the 16-bit accumulator, then increment the step counter.
REQ-020: Accumulator arithmetic SHALL be 16-bit unsigned; intermediate and final sums never exceed 0xFE01, so no carry-out is required.
REQ-021: On the step-3 edge, state SHALL go to DONE; out_valid SHALL rise exactly 4 cycles after the acceptance edge.
REQ-022: DONE: out_valid=1, in_ready=0, busy=0; P SHALL equal the accumulator and remain stable until handshake.
REQ-023: In DONE, an edge with out_ready=1 SHALL complete transfer, state -> IDLE; out_valid=0 and in_ready=1 the following cycle.
REQ-024: In DONE with out_ready=0, the state SHALL hold indefinitely with P unchanged (backpressure).
REQ-025: No new operands SHALL be accepted in the same cycle as the output handshake; minimum issue interval is 6 cycles.
REQ-026: P SHALL reflect the accumulator in all states; its value is meaningful only when out_valid=1.
REQ-027: out_ready while out_valid=0 SHALL have no effect.

Reset
REQ-028: On any edge with rst=1, regardless of state or step, state SHALL -> IDLE; accumulator, operand registers, step counter and P SHALL be 0.
REQ-029: After reset: in_ready=1, out_valid=0, busy=0.
REQ-030: rst SHALL take priority over in_valid and out_ready in the same cycle; an in-flight operation is discarded and never produces out_valid.

Verification
REQ-031: Reset, then A=0x12, B=0x34, in_valid pulse, out_ready=1 -> out_valid at acceptance+4, P=0x03A8, busy high exactly 4 cycles.
REQ-032: A=0xFF, B=0xFF -> P=0xFE01; A=0x00, B=0x5A -> P=0x0000; A=0x0F, B=0xF0 -> P=0x0E10.
REQ-033: Backpressure: A=0x80, B=0x02, out_ready held 0 for 5 cycles after out_valid -> P=0x0100 stable, in_ready=0 throughout; out_ready=1 -> IDLE next cycle.
REQ-034: Ignore while busy: accept A=0x03, B=0x05, then drive in_valid=1 with A=0xAA, B=0xBB during MUL -> P=0x000F, second request not accepted until in_ready=1.
REQ-035: Reset mid-operation: assert rst during step 2 -> next cycle IDLE, P=0, out_valid never asserts; subsequent A=0x07, B=0x09 yields P=0x003F.
REQ-036: Randomized: 1000 random A, B pairs with random out_ready stalls -> every P equals A*B, one output per accepted input, in order.
